// File: rtl/crc32.sv
// Word-parallel CRC-32/MPEG-2 generator: absorbs one 32-bit word per enabled
// clock, MSB first, and exposes the running CRC register directly.
module crc32 #(
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  // Bit-serial update unrolled over all 32 data bits, bit 31 first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    // NOTE: blocking assignments are correct here; each iteration must see
    // the value produced by the previous one within the same evaluation.
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  always_comb begin
    crc_next = crc_step(crc_reg, data_in);
  end

  // rst takes priority over crc_en; data_in is only consumed when enabled,
  // so unknown data during idle cycles never reaches the register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so every register samples
    // pre-edge values regardless of process ordering.
    if (rst) begin
      crc_reg <= INIT;
    end else if (crc_en) begin
      crc_reg <= crc_next;
    end
  end

  assign crc_out = crc_reg;

endmodule

// File: tb/tb_crc32.sv
// Directed and randomised checks of crc32 against a long-division reference
// that computes ((crc ^ data) * x^32) mod P on a 64-bit dividend.
module tb_crc32;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic        clk;
  logic        rst;
  logic        crc_en;
  logic [31:0] data_in;
  logic [31:0] crc_out;

  int          tests_run;
  int          tests_failed;
  logic [31:0] model;
  logic [31:0] stream_final;

  crc32 #(.POLY(POLY), .INIT(INIT)) dut (
    .clk     (clk),
    .rst     (rst),
    .crc_en  (crc_en),
    .data_in (data_in),
    .crc_out (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial long division: shift the XORed word up by 32 and reduce by
  // the full 33-bit generator, highest remaining term first.
  function automatic logic [31:0] ref_step(input logic [31:0] crc,
                                           input logic [31:0] data);
    logic [63:0] r;
    logic [63:0] g;
    r = {crc ^ data, 32'h0};
    g = {31'h0, 1'b1, POLY};
    for (int i = 63; i >= 32; i--) begin
      if (r[i]) r = r ^ (g << (i - 32));
    end
    return r[31:0];
  endfunction

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic en, input logic [31:0] d);
    rst     = r;
    crc_en  = en;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    tests_run++;
    if (crc_out !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL reset_value: got %08h expected %08h", crc_out, 32'hFFFFFFFF);
    end
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0, 32'hxxxxxxxx);
      tests_run++;
      if (crc_out !== 32'hFFFFFFFF) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: got %08h expected %08h", i, crc_out, 32'hFFFFFFFF);
      end
    end
  endtask

  task automatic test_cancellation();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFFFFFF);
    tests_run++;
    if (crc_out !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL cancel: got %08h expected %08h", crc_out, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'h00000000);
      tests_run++;
      if (crc_out !== 32'h00000000) begin
        tests_failed++;
        $display("FAIL zero_feed[%0d]: got %08h expected %08h", i, crc_out, 32'h0);
      end
    end
  endtask

  // Starts from state 0 left by test_cancellation.
  task automatic test_polynomial();
    logic [31:0] vec_d   [4];
    logic [31:0] vec_exp [4];
    vec_d   = '{32'h00000001, 32'h04C11DB7, 32'h00000003, 32'h0D4326D9};
    vec_exp = '{32'h04C11DB7, 32'h00000000, 32'h0D4326D9, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, vec_d[i]);
      tests_run++;
      if (crc_out !== vec_exp[i]) begin
        tests_failed++;
        $display("FAIL poly[%0d]: got %08h expected %08h", i, crc_out, vec_exp[i]);
      end
    end
    cycle(1'b0, 1'b1, 32'h00000002);
    tests_run++;
    if (crc_out !== 32'h09823B6E) begin
      tests_failed++;
      $display("FAIL poly_x33: got %08h expected %08h", crc_out, 32'h09823B6E);
    end
    cycle(1'b1, 1'b1, 32'h12345678);
    tests_run++;
    if (crc_out !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL rst_priority: got %08h expected %08h", crc_out, 32'hFFFFFFFF);
    end
  endtask

  task automatic test_stream();
    cycle(1'b1, 1'b0, 32'h0);
    model = INIT;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b1, 32'(k));
      model = ref_step(model, 32'(k));
      tests_run++;
      if (crc_out !== model) begin
        tests_failed++;
        $display("FAIL stream[%0d]: got %08h expected %08h", k, crc_out, model);
      end
    end
    stream_final = model;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0, 32'hxxxxxxxx);
      tests_run++;
      if (crc_out !== stream_final) begin
        tests_failed++;
        $display("FAIL stream_hold[%0d]: got %08h expected %08h", i, crc_out, stream_final);
      end
    end
  endtask

  task automatic test_midstream_reset();
    for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, 32'(k + 100));
    cycle(1'b1, 1'b1, 32'hDEADBEEF);
    tests_run++;
    if (crc_out !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL mid_reset: got %08h expected %08h", crc_out, 32'hFFFFFFFF);
    end
    for (int k = 1; k <= 6; k++) cycle(1'b0, 1'b1, 32'(k));
    tests_run++;
    if (crc_out !== stream_final) begin
      tests_failed++;
      $display("FAIL refeed: got %08h expected %08h", crc_out, stream_final);
    end
  endtask

  task automatic test_random();
    logic        r;
    logic        en;
    logic [31:0] d;
    cycle(1'b1, 1'b0, 32'h0);
    model = INIT;
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(63) == 0);
      en = $urandom_range(1);
      d  = $urandom;
      cycle(r, en, d);
      if (r)       model = INIT;
      else if (en) model = ref_step(model, d);
      tests_run++;
      if (crc_out !== model) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %08h expected %08h", i, crc_out, model);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    crc_en       = 1'b0;
    data_in      = 32'h0;
    model        = INIT;
    stream_final = 32'h0;
    test_reset();
    test_cancellation();
    test_polynomial();
    test_stream();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
